accum_bank: RTL

- Parametrised successor to the single adder/accumulator on the Basys2 board.
- Holds NUM_REGS operand registers and one accumulator. Operations are triggered by raw button levels: load, add, subtract and clear.
- Overflow handling is selectable: wrap or saturate.
- Provides an operation counter and a registered display-select mux that feeds the seven-segment driver and LEDs.

---
 rtl/accum_bank.sv | 132 +++++++++++++
 1 files changed

// File: rtl/accum_bank.sv
// accum_bank: bank of operand registers feeding one accumulator.
// Buttons are raw levels; each rising edge triggers exactly one operation.
// Priority on simultaneous edges is clear > load > add > sub.
// Overflow either wraps or clamps, depending on SATURATE.
// A registered display mux selects acc, count or an operand register.
module accum_bank #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2,
  parameter int COUNT_W  = 8,
  parameter int SATURATE = 0,
  parameter int SEL_W    = 3
) (
  input  logic               MCLK,
  input  logic               reset,
  input  logic [WIDTH-1:0]   din,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               btn_load,
  input  logic               btn_add,
  input  logic               btn_sub,
  input  logic               btn_clear,
  input  logic [SEL_W-1:0]   disp_sel,
  output logic [WIDTH-1:0]   disp_val,
  output logic [WIDTH-1:0]   acc,
  output logic [COUNT_W-1:0] count,
  output logic               ovf,
  output logic               done
);

  // Button bit order: {clear, load, add, sub}.
  logic [3:0] btn_now, btn_q, btn_d, fire;

  logic [NUM_REGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   disp_q, disp_d;

  logic [WIDTH-1:0]   operand, diff;
  logic [WIDTH:0]     sum;
  logic               borrow;

  assign btn_now = {btn_clear, btn_load, btn_add, btn_sub};
  assign fire    = btn_now & ~btn_q;

  // Operand fetch and the add/sub datapath.
  // An out-of-range addr reads as 0, so add/sub leave acc unchanged.
  always_comb begin
    operand = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (addr == ADDR_W'(i)) operand = regs_q[i];
    sum    = {1'b0, acc_q} + {1'b0, operand};
    borrow = operand > acc_q;
    diff   = acc_q - operand;
  end

  // Next-state logic: only the highest-priority fired operation executes.
  always_comb begin
    btn_d   = btn_now;
    regs_d  = regs_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (fire[3]) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      done_d  = 1'b1;
    end else if (fire[2]) begin
      // A load to an out-of-range address is dropped, but it still counts as executed.
      for (int i = 0; i < NUM_REGS; i++)
        if (addr == ADDR_W'(i)) regs_d[i] = din;
      done_d = 1'b1;
    end else if (fire[1]) begin
      acc_d = sum[WIDTH-1:0];
      if (sum[WIDTH]) begin
        ovf_d = 1'b1;
        if (SATURATE != 0) acc_d = '1;
      end
      count_d = count_q + COUNT_W'(1);
      done_d  = 1'b1;
    end else if (fire[0]) begin
      acc_d = diff;
      if (borrow) begin
        ovf_d = 1'b1;
        if (SATURATE != 0) acc_d = '0;
      end
      count_d = count_q + COUNT_W'(1);
      done_d  = 1'b1;
    end
  end

  // Display source select.
  // It reads the registered state, so the shown value lags any change by one cycle.
  always_comb begin
    disp_d = '0;
    if (disp_sel == '0) disp_d = acc_q;
    else if (disp_sel == SEL_W'(1)) disp_d = WIDTH'(count_q);
    for (int i = 0; i < NUM_REGS; i++)
      if (disp_sel == SEL_W'(i + 2)) disp_d = regs_q[i];
  end

  // State registers.
  // Edge history tracks the buttons even during reset, so a button held through reset does not fire.
  always_ff @(posedge MCLK) begin
    btn_q <= btn_d;
    if (reset) begin
      regs_q  <= '0;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      disp_q  <= '0;
    end else begin
      regs_q  <= regs_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      disp_q  <= disp_d;
    end
  end

  assign acc      = acc_q;
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign done     = done_q;
  assign disp_val = disp_q;

endmodule
